// File: rtl/reset_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reset_seq_pkg                                                      |
// | Shared state encoding and counter sizing for the reset sequencer.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package reset_seq_pkg;

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_STRETCH = 2'd1,
        S_RELEASE = 2'd2,
        S_RUN     = 2'd3
    } seq_state_t;

    // One counter serves both the stretch and the inter-domain gap.
    function automatic int cnt_width(input int stretch_cycles, input int gap_cycles);
        int longest;
        longest = (stretch_cycles > gap_cycles) ? stretch_cycles : gap_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sync_chain.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reset_sync_chain                                                   |
// | Asynchronous-assert, synchronous-release reset synchronizer.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module reset_sync_chain #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    output logic rst_sync
);

    logic [DEPTH-1:0] r_stages;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stages <= '1;
        end else begin
            r_stages <= {r_stages[DEPTH-2:0], 1'b0};
        end
    end

    assign rst_sync = r_stages[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reset_sequencer                                                    |
// | Stretches and releases domain resets in order; warm-reset handshake.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int STRETCH     = 16,
    parameter int NUM_DOMAINS = 3,
    parameter int GAP         = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sw_reset_req,
    output logic                   sw_reset_ack,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   done
);

    localparam int C_CNT_W = cnt_width(STRETCH, GAP);
    localparam int C_IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    // Loads are one less than the period: the release happens on the edge
    // that observes a zero count.
    localparam logic [C_CNT_W-1:0] C_STRETCH_LOAD = C_CNT_W'(STRETCH - 1);
    localparam logic [C_CNT_W-1:0] C_GAP_LOAD     = C_CNT_W'(GAP - 1);
    localparam logic [C_IDX_W-1:0] C_LAST_IDX     = C_IDX_W'(NUM_DOMAINS - 1);
    localparam logic [C_IDX_W-1:0] C_FIRST_GAP    = C_IDX_W'(1);

    logic               w_rst_sync;
    seq_state_t         r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_IDX_W-1:0] r_idx;

    reset_sync_chain #(
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .rst_sync (w_rst_sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_HOLD;
            r_cnt        <= '0;
            r_idx        <= '0;
            domain_rst   <= '1;
            done         <= 1'b0;
            sw_reset_ack <= 1'b0;
        end else begin
            sw_reset_ack <= 1'b0;
            case (r_state)
                S_HOLD: begin
                    if (!w_rst_sync) begin
                        r_state <= S_STRETCH;
                        r_cnt   <= C_STRETCH_LOAD;
                    end
                end

                S_STRETCH: begin
                    if (r_cnt == '0) begin
                        domain_rst[0] <= 1'b0;
                        if (NUM_DOMAINS == 1) begin
                            r_state <= S_RUN;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_RELEASE;
                            r_cnt   <= C_GAP_LOAD;
                            r_idx   <= C_FIRST_GAP;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_RELEASE: begin
                    if (r_cnt == '0) begin
                        domain_rst[r_idx] <= 1'b0;
                        if (r_idx == C_LAST_IDX) begin
                            r_state <= S_RUN;
                            done    <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                            r_cnt <= C_GAP_LOAD;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_RUN: begin
                    if (sw_reset_req) begin
                        domain_rst   <= '1;
                        sw_reset_ack <= 1'b1;
                        done         <= 1'b0;
                        r_state      <= S_STRETCH;
                        r_cnt        <= C_STRETCH_LOAD;
                        r_idx        <= '0;
                    end
                end

                default: begin
                    r_state <= S_HOLD;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_reset_sequencer                                                 |
// | Directed table-driven bench for reset_sequencer.                   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req = 1'b0;
    logic       ack;
    logic       done;
    logic [2:0] dom;

    logic       rst_d = 1'b0;
    logic       req_d = 1'b0;
    logic       ack_d;
    logic       done_d;
    logic [0:0] dom_d;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    reset_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .sw_reset_req (req),
        .sw_reset_ack (ack),
        .domain_rst   (dom),
        .done         (done)
    );

    reset_sequencer #(
        .SYNC_STAGES (2),
        .STRETCH     (1),
        .NUM_DOMAINS (1),
        .GAP         (4)
    ) dut_d (
        .clk          (clk),
        .rst          (rst_d),
        .sw_reset_req (req_d),
        .sw_reset_ack (ack_d),
        .domain_rst   (dom_d),
        .done         (done_d)
    );

    typedef struct {
        int         edge_n;
        logic [2:0] dom;
        logic       done;
        logic       ack;
    } vec_t;

    vec_t po_vec[11];

    // Expected {domain_rst, done} for default parameters, rel edges after STRETCH entry.
    function automatic logic [3:0] seq_exp(input int rel);
        if (rel < 16)      return {3'b111, 1'b0};
        else if (rel < 20) return {3'b110, 1'b0};
        else if (rel < 24) return {3'b100, 1'b0};
        else               return {3'b000, 1'b1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk(input string name, input logic [2:0] d_exp, input logic dn_exp, input logic a_exp);
        checks++;
        if ({dom, done, ack} !== {d_exp, dn_exp, a_exp}) begin
            errors++;
            $display("FAIL %s edge=%0d: got dom=%b done=%b ack=%b, want dom=%b done=%b ack=%b",
                     name, cyc, dom, done, ack, d_exp, dn_exp, a_exp);
        end
    endtask

    task automatic chk_d(input string name, input logic d_exp, input logic dn_exp);
        checks++;
        if ({dom_d, done_d, ack_d} !== {d_exp, dn_exp, 1'b0}) begin
            errors++;
            $display("FAIL %s edge=%0d: got dom=%b done=%b ack=%b, want dom=%b done=%b ack=0",
                     name, cyc, dom_d, done_d, ack_d, d_exp, dn_exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic run_table(input string name);
        foreach (po_vec[i]) begin
            tick_to(po_vec[i].edge_n);
            chk(name, po_vec[i].dom, po_vec[i].done, po_vec[i].ack);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int t;
        logic [3:0] e;

        po_vec[0]  = '{1,  3'b111, 1'b0, 1'b0};
        po_vec[1]  = '{3,  3'b111, 1'b0, 1'b0};
        po_vec[2]  = '{4,  3'b111, 1'b0, 1'b0};
        po_vec[3]  = '{19, 3'b111, 1'b0, 1'b0};
        po_vec[4]  = '{20, 3'b110, 1'b0, 1'b0};
        po_vec[5]  = '{21, 3'b110, 1'b0, 1'b0};
        po_vec[6]  = '{23, 3'b110, 1'b0, 1'b0};
        po_vec[7]  = '{24, 3'b100, 1'b0, 1'b0};
        po_vec[8]  = '{27, 3'b100, 1'b0, 1'b0};
        po_vec[9]  = '{28, 3'b000, 1'b1, 1'b0};
        po_vec[10] = '{30, 3'b000, 1'b1, 1'b0};

        // Reset asserted before any clock edge must set outputs at once.
        #1;
        rst   = 1'b1;
        rst_d = 1'b1;
        #1;
        chk("async_reset", 3'b111, 1'b0, 1'b0);
        chk_d("async_reset_d", 1'b1, 1'b0);

        do_reset();
        run_table("power_on");

        // Warm reset: request for one cycle while in RUN.
        req = 1'b1;
        tick();
        t = cyc;
        chk("warm_take", 3'b111, 1'b0, 1'b1);
        req = 1'b0;
        tick();
        chk("warm_ack_drop", 3'b111, 1'b0, 1'b0);
        tick_to(t + 15); chk("warm_t15", 3'b111, 1'b0, 1'b0);
        tick_to(t + 16); chk("warm_t16", 3'b110, 1'b0, 1'b0);
        tick_to(t + 19); chk("warm_t19", 3'b110, 1'b0, 1'b0);
        tick_to(t + 20); chk("warm_t20", 3'b100, 1'b0, 1'b0);
        tick_to(t + 23); chk("warm_t23", 3'b100, 1'b0, 1'b0);
        tick_to(t + 24); chk("warm_t24", 3'b000, 1'b1, 1'b0);

        // Request held high outside RUN: taken only once RUN is reached.
        do_reset();
        tick_to(9);
        req = 1'b1;
        for (int n = 10; n <= 28; n++) begin
            tick_to(n);
            e = seq_exp(n - 4);
            chk("early_req", e[3:1], e[0], 1'b0);
        end
        tick_to(29);
        chk("early_req_take", 3'b111, 1'b0, 1'b1);
        for (int n = 30; n <= 53; n++) begin
            tick_to(n);
            e = seq_exp(n - 29);
            chk("held_req_reseq", e[3:1], e[0], 1'b0);
        end
        tick_to(54);
        chk("held_req_retake", 3'b111, 1'b0, 1'b1);
        req = 1'b0;
        tick_to(55);
        chk("held_req_ack_drop", 3'b111, 1'b0, 1'b0);

        // Reset in the middle of the release sequence.
        do_reset();
        tick_to(22);
        chk("mid_pre", 3'b110, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_async", 3'b111, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        run_table("post_mid");

        // Degenerate configuration on the second instance.
        @(negedge clk);
        rst_d = 1'b0;
        cyc   = 0;
        tick_to(1); chk_d("degen_e1", 1'b1, 1'b0);
        tick_to(3); chk_d("degen_e3", 1'b1, 1'b0);
        tick_to(4); chk_d("degen_e4", 1'b0, 1'b1);
        tick_to(6); chk_d("degen_e6", 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
